node_param: RTL and testbench
=============================

# node_param

Parametrised network endpoint between the testbench and its router port. Buffers testbench packets in an inbound queue and serialises them MSB-first as PHIT_W-bit phits onto the router link. Reassembles phits arriving from the router into whole packets and holds them in an output queue with a ready/valid handshake to the testbench. The output queue lets router-side reception continue while the testbench stalls. It generalises the fixed 32-bit/8-bit endpoint in width, queue depth and backpressure, and adds link-protocol error detection.

## Interface
- PKT_W, 32: packet width in bits. Must be a multiple of PHIT_W.
- PHIT_W, 8: link phit width in bits.
- IN_DEPTH, 4: inbound (TB→router) queue depth, ≥1.
- OUT_DEPTH, 2: output (router→TB) queue depth, ≥1.
- NODEID, 0: node identifier; carried only, no logic depends on it.
- Derived: PHITS = PKT_W/PHIT_W, must be ≥2.

- clk  in  1  single clock, all state on posedge.
- rst_b  in  1  asynchronous, active-high reset (1 = reset).
- pkt_in  in  PKT_W  packet from TB.
- pkt_in_avail  in  1  write strobe for pkt_in.
- cQ_full  out  1  inbound queue full.
- pkt_out  out  PKT_W  head of output queue.
- pkt_out_avail  out  1  output queue non-empty.
- pkt_out_ready  in  1  TB accepts pkt_out this cycle.
- free_outbound  in  1  router can accept a new packet.
- put_outbound  out  1  phit valid on payload_outbound.
- payload_outbound  out  PHIT_W  outbound phit.
- free_inbound  out  1  node can accept a new packet.
- put_inbound  in  1  phit valid on payload_inbound.
- payload_inbound  in  PHIT_W  inbound phit.
- proto_err  out  1  sticky link-protocol violation flag.

## Operation
- Inbound queue:
  - Circular, IN_DEPTH entries.
  - Writes at the edge where pkt_in_avail=1 and cQ_full=0.
  - If pkt_in_avail=1 while cQ_full=1, the write is dropped with no state change.
  - Pops only when the serialiser loads.
- Serialiser FSM:
  - States IDLE and SEND, with a shift register and phit counter 0..PHITS-1.
  - IDLE: if the queue is non-empty and free_outbound=1, load the head into the shift register, pop, set count=0 and go to SEND.
  - SEND: put_outbound=1 and payload_outbound = shreg[PKT_W-1 -: PHIT_W]. Each edge shifts left by PHIT_W and increments the count.
  - At count=PHITS-1: if the queue is non-empty and free_outbound=1, reload back-to-back and stay in SEND. Otherwise go to IDLE.
  - free_outbound is ignored mid-packet.
- Reassembler FSM:
  - States IDLE and RECV, with a phit counter.
  - free_inbound = (state==IDLE) && (output count < OUT_DEPTH).
  - IDLE with put_inbound=1 and free_inbound=1: capture the first phit into the LSBs, set count=1 and go to RECV.
  - RECV with put_inbound=1: shift left by PHIT_W and OR in the phit. On the PHITS-th phit, write the assembled packet into the output queue at that edge and go to IDLE.
  - RECV with put_inbound=0 before the last phit: discard the partial packet, set proto_err and go to IDLE.
  - IDLE with put_inbound=1 while free_inbound=0: ignore the phit and set proto_err.
- Output queue:
  - Circular, OUT_DEPTH entries.
  - pkt_out = head; pkt_out_avail = ~empty.
  - Pops at the edge where pkt_out_avail and pkt_out_ready are both 1.
  - A write and a pop in the same edge leave the count unchanged.
  - The queue never overflows because free_inbound gates new packets.
- proto_err clears only on reset.

## Timing
- Reset values:
  - All queues empty and both FSMs IDLE.
  - cQ_full=0, pkt_out_avail=0, put_outbound=0, payload_outbound=0.
  - free_inbound=1, proto_err=0, pkt_out=0.
  - Reset asserted mid-packet aborts immediately; no partial packet survives.
- Outbound latency:
  - pkt_in sampled at edge k into an empty queue, with free_outbound=1.
  - Load at edge k+1; phits are valid during cycles k+1..k+PHITS.
- Back-to-back packets: zero idle cycles between packets when the queue stays non-empty and free_outbound=1.
- Inbound latency: the last phit sampled at edge m gives pkt_out_avail=1 after edge m.
- free_inbound is low throughout RECV. It returns high the cycle after the last phit if the output queue has space.
- Queue pointers wrap modulo depth. Counters are wide enough to hold depth inclusive.

## Test plan
- Default params: write 32'hDEADBEEF, free_outbound=1 → put_outbound high for 4 cycles with phits DE, AD, BE, EF; queue empty afterwards.
- Write 5 packets with free_outbound=0 → cQ_full=1 after 4 writes; the 5th is dropped. Raise free_outbound → 4 packets sent back-to-back, 16 consecutive put cycles.
- Inbound phits 12, 34, 56, 78 with pkt_out_ready=1 → pkt_out=32'h12345678 and pkt_out_avail=1 the cycle after the last phit.
- pkt_out_ready=0, send 2 packets → free_inbound=0 after the 2nd. Inject a put_inbound → proto_err=1 and the queue is unchanged. Raise pkt_out_ready → both packets drain in order.
- put_inbound drops after 2 phits → proto_err=1, nothing written, free_inbound=1 the next cycle.
- PKT_W=64, PHIT_W=16, IN_DEPTH=3: 64'h0123456789ABCDEF → phits 0123, 4567, 89AB, CDEF. Assert rst_b mid-send → put_outbound=0 immediately and queues empty.

Source files
------------

// File: rtl/node_param.sv
// Network endpoint: TB packets are queued and serialised MSB-first as phits; router phits are reassembled into an output queue.
// Outbound: load one edge after enqueue, PHITS phit cycles, back-to-back when possible. Inbound: packet visible after its last phit.

// Circular queue; pushes while full are dropped, head reads 0 while empty.
module node_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module node_param #(
  parameter int PKT_W     = 32,
  parameter int PHIT_W    = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2,
  parameter int NODEID    = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_in_avail,
  output logic              cQ_full,
  output logic [PKT_W-1:0]  pkt_out,
  output logic              pkt_out_avail,
  input  logic              pkt_out_ready,
  input  logic              free_outbound,
  output logic              put_outbound,
  output logic [PHIT_W-1:0] payload_outbound,
  output logic              free_inbound,
  input  logic              put_inbound,
  input  logic [PHIT_W-1:0] payload_inbound,
  output logic              proto_err
);
  localparam int PHITS = PKT_W / PHIT_W;
  localparam int CNT_W = $clog2(PHITS);
  localparam int ACC_W = PKT_W - PHIT_W;

  typedef enum logic {S_IDLE, S_SEND} ser_state_t;
  typedef enum logic {R_IDLE, R_RECV} rx_state_t;

  logic [PKT_W-1:0] in_head;
  logic             in_empty, out_empty, out_full;

  ser_state_t       ser_state, ser_next;
  logic [PKT_W-1:0] ser_sh;
  logic [CNT_W-1:0] ser_cnt;
  logic             ser_last, ser_load;

  rx_state_t        rx_state, rx_next;
  logic [ACC_W-1:0] rx_acc;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_take, rx_last, err_set;

  node_fifo #(.W(PKT_W), .DEPTH(IN_DEPTH)) u_in_q (
    .clk(clk), .rst(rst_b), .push(pkt_in_avail), .push_dat(pkt_in),
    .pop(ser_load), .head_dat(in_head), .empty(in_empty), .full(cQ_full)
  );

  node_fifo #(.W(PKT_W), .DEPTH(OUT_DEPTH)) u_out_q (
    .clk(clk), .rst(rst_b), .push(rx_last), .push_dat({rx_acc, payload_inbound}),
    .pop(pkt_out_avail && pkt_out_ready), .head_dat(pkt_out), .empty(out_empty), .full(out_full)
  );

  assign pkt_out_avail = !out_empty;

  // Serialiser: a reload on the last phit keeps the link busy without a gap.
  assign ser_last = (ser_state == S_SEND) && (ser_cnt == CNT_W'(PHITS - 1));
  assign ser_load = !in_empty && free_outbound && ((ser_state == S_IDLE) || ser_last);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) ser_state <= S_IDLE;
    else       ser_state <= ser_next;
  end

  always_comb begin
    ser_next = ser_state;
    unique case (ser_state)
      S_IDLE:  if (ser_load) ser_next = S_SEND;
      S_SEND:  if (ser_last && !ser_load) ser_next = S_IDLE;
      default: ser_next = S_IDLE;
    endcase
  end

  always_comb begin
    put_outbound     = 1'b0;
    payload_outbound = '0;
    if (ser_state == S_SEND) begin
      put_outbound     = 1'b1;
      payload_outbound = ser_sh[PKT_W-1 -: PHIT_W];
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ser_sh  <= '0;
      ser_cnt <= '0;
    end else if (ser_load) begin
      ser_sh  <= in_head;
      ser_cnt <= '0;
    end else if (ser_state == S_SEND) begin
      ser_sh  <= ser_sh << PHIT_W;
      ser_cnt <= ser_cnt + 1'b1;
    end
  end

  // Reassembler: only the first PHITS-1 phits are held; the last goes straight into the queue.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE:  if (rx_take) rx_next = R_RECV;
      R_RECV:  if (!put_inbound || rx_last) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    free_inbound = (rx_state == R_IDLE) && !out_full;
    rx_take      = free_inbound && put_inbound;
    rx_last      = (rx_state == R_RECV) && put_inbound && (rx_cnt == CNT_W'(PHITS - 1));
    err_set      = ((rx_state == R_IDLE) && put_inbound && !free_inbound) ||
                   ((rx_state == R_RECV) && !put_inbound);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rx_acc <= '0;
      rx_cnt <= '0;
    end else if (rx_take) begin
      rx_acc <= ACC_W'(payload_inbound);
      rx_cnt <= CNT_W'(1);
    end else if ((rx_state == R_RECV) && put_inbound) begin
      rx_acc <= ACC_W'({rx_acc, payload_inbound});
      rx_cnt <= rx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)        proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
  end
endmodule

// File: tb/tb_node_param.sv
// Bench for node_param: default 32/8 instance plus a 64/16 depth-3 instance.
module tb_node_param;
  localparam int AW = 32, AP = 8, APH = AW / AP;
  localparam int BW = 64, BP = 16, BPH = BW / BP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          a_rst, a_pkt_in_avail, a_cq_full, a_pkt_out_avail, a_pkt_out_ready;
  logic          a_free_out, a_put_out, a_free_in, a_put_in, a_err;
  logic [AW-1:0] a_pkt_in, a_pkt_out;
  logic [AP-1:0] a_pay_out, a_pay_in;

  logic          b_rst, b_pkt_in_avail, b_cq_full, b_pkt_out_avail, b_pkt_out_ready;
  logic          b_free_out, b_put_out, b_free_in, b_put_in, b_err;
  logic [BW-1:0] b_pkt_in, b_pkt_out;
  logic [BP-1:0] b_pay_out, b_pay_in;

  node_param #(.PKT_W(AW), .PHIT_W(AP), .IN_DEPTH(4), .OUT_DEPTH(2), .NODEID(1)) dut_a (
    .clk(clk), .rst_b(a_rst), .pkt_in(a_pkt_in), .pkt_in_avail(a_pkt_in_avail),
    .cQ_full(a_cq_full), .pkt_out(a_pkt_out), .pkt_out_avail(a_pkt_out_avail),
    .pkt_out_ready(a_pkt_out_ready), .free_outbound(a_free_out), .put_outbound(a_put_out),
    .payload_outbound(a_pay_out), .free_inbound(a_free_in), .put_inbound(a_put_in),
    .payload_inbound(a_pay_in), .proto_err(a_err)
  );

  node_param #(.PKT_W(BW), .PHIT_W(BP), .IN_DEPTH(3), .OUT_DEPTH(2), .NODEID(2)) dut_b (
    .clk(clk), .rst_b(b_rst), .pkt_in(b_pkt_in), .pkt_in_avail(b_pkt_in_avail),
    .cQ_full(b_cq_full), .pkt_out(b_pkt_out), .pkt_out_avail(b_pkt_out_avail),
    .pkt_out_ready(b_pkt_out_ready), .free_outbound(b_free_out), .put_outbound(b_put_out),
    .payload_outbound(b_pay_out), .free_inbound(b_free_in), .put_inbound(b_put_in),
    .payload_inbound(b_pay_in), .proto_err(b_err)
  );

  // Collects whole packets from instance A's outbound link, MSB phit first.
  logic [AW-1:0] mon_acc;
  int            mon_n;
  logic [AW-1:0] rx_q[$];
  always @(negedge clk or posedge a_rst) begin
    if (a_rst) begin
      rx_q.delete();
      mon_n   = 0;
      mon_acc = '0;
    end else if (a_put_out === 1'b1) begin
      mon_acc = {mon_acc[AW-AP-1:0], a_pay_out};
      mon_n++;
      if (mon_n == APH) begin
        rx_q.push_back(mon_acc);
        mon_n = 0;
      end
    end
  end

  function automatic logic [AP-1:0] a_phit(input logic [AW-1:0] p, input int i);
    return AP'(p >> (AW - AP * (i + 1)));
  endfunction

  function automatic logic [BP-1:0] b_phit(input logic [BW-1:0] p, input int i);
    return BP'(p >> (BW - BP * (i + 1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    a_pkt_in_avail = 1'b0; a_put_in = 1'b0; a_free_out = 1'b0; a_pkt_out_ready = 1'b0;
    tick(); tick();
    a_rst = 1'b0;
    tick();
  endtask

  task automatic send_a(input logic [AW-1:0] p);
    for (int i = 0; i < APH; i++) begin
      a_put_in = 1'b1;
      a_pay_in = a_phit(p, i);
      tick();
    end
    a_put_in = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_pkt_in = '0; a_pkt_in_avail = 1'b0; a_pkt_out_ready = 1'b0; a_free_out = 1'b0; a_put_in = 1'b0; a_pay_in = '0;
    b_pkt_in = '0; b_pkt_in_avail = 1'b0; b_pkt_out_ready = 1'b0; b_free_out = 1'b0; b_put_in = 1'b0; b_pay_in = '0;
    #1;
    total++; if (a_cq_full !== 1'b0) begin bad++; $display("FAIL reset_cq_full got=%b want=0", a_cq_full); end
    total++; if (a_pkt_out_avail !== 1'b0) begin bad++; $display("FAIL reset_avail got=%b want=0", a_pkt_out_avail); end
    total++; if (a_put_out !== 1'b0) begin bad++; $display("FAIL reset_put got=%b want=0", a_put_out); end
    total++; if (a_pay_out !== '0) begin bad++; $display("FAIL reset_payload got=%h want=0", a_pay_out); end
    total++; if (a_free_in !== 1'b1) begin bad++; $display("FAIL reset_free_in got=%b want=1", a_free_in); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", a_err); end
    total++; if (a_pkt_out !== '0) begin bad++; $display("FAIL reset_pkt_out got=%h want=0", a_pkt_out); end
    total++; if (b_put_out !== 1'b0 || b_free_in !== 1'b1 || b_pkt_out !== '0) begin
      bad++; $display("FAIL reset_b got put=%b free=%b pkt=%h want 0/1/0", b_put_out, b_free_in, b_pkt_out);
    end
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_send();
    logic [AW-1:0] p;
    p = 32'hDEADBEEF;
    reset_a();
    a_free_out = 1'b1;
    a_pkt_in = p; a_pkt_in_avail = 1'b1;
    tick();
    a_pkt_in_avail = 1'b0;
    total++; if (a_put_out !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", a_put_out); end
    for (int i = 0; i < APH; i++) begin
      tick();
      total++;
      if (a_put_out !== 1'b1 || a_pay_out !== a_phit(p, i)) begin
        bad++; $display("FAIL single_phit%0d got put=%b data=%h want 1/%h", i, a_put_out, a_pay_out, a_phit(p, i));
      end
    end
    tick();
    total++; if (a_put_out !== 1'b0) begin bad++; $display("FAIL single_tail got=%b want=0", a_put_out); end
    total++; if (rx_q.size() != 1 || rx_q[0] !== p) begin
      bad++; $display("FAIL single_pkt got n=%0d want n=1 pkt=%h", rx_q.size(), p);
    end
  endtask

  task automatic test_full_drop();
    logic [AW-1:0] p[5];
    int puts, gaps;
    reset_a();
    puts = 0; gaps = 0;
    for (int i = 0; i < 5; i++) begin
      p[i] = $urandom;
      a_pkt_in = p[i]; a_pkt_in_avail = 1'b1;
      tick();
      if (a_put_out !== 1'b0) puts++;
      total++;
      if (a_cq_full !== 1'(i >= 3)) begin bad++; $display("FAIL full_flag%0d got=%b want=%b", i, a_cq_full, i >= 3); end
    end
    a_pkt_in_avail = 1'b0;
    total++; if (puts != 0) begin bad++; $display("FAIL hold_no_put got=%0d want=0", puts); end
    a_free_out = 1'b1;
    for (int i = 0; i < 4 * APH; i++) begin
      tick();
      if (a_put_out !== 1'b1) gaps++;
    end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    tick();
    total++; if (a_put_out !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b want=0", a_put_out); end
    total++; if (rx_q.size() != 4) begin bad++; $display("FAIL drop_count got=%0d want=4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== p[i]) begin bad++; $display("FAIL b2b_order%0d want=%h", i, p[i]); end
    end
  endtask

  task automatic test_inbound();
    logic [AW-1:0] p;
    p = 32'h12345678;
    reset_a();
    a_pkt_out_ready = 1'b1;
    for (int i = 0; i < APH; i++) begin
      a_put_in = 1'b1; a_pay_in = a_phit(p, i);
      tick();
      if (i < APH - 1) begin
        total++; if (a_free_in !== 1'b0) begin bad++; $display("FAIL in_free_recv%0d got=%b want=0", i, a_free_in); end
      end
    end
    a_put_in = 1'b0;
    total++; if (a_pkt_out_avail !== 1'b1) begin bad++; $display("FAIL in_avail got=%b want=1", a_pkt_out_avail); end
    total++; if (a_pkt_out !== p) begin bad++; $display("FAIL in_pkt got=%h want=%h", a_pkt_out, p); end
    total++; if (a_free_in !== 1'b1) begin bad++; $display("FAIL in_free_after got=%b want=1", a_free_in); end
    tick();
    total++; if (a_pkt_out_avail !== 1'b0) begin bad++; $display("FAIL in_popped got=%b want=0", a_pkt_out_avail); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL in_err got=%b want=0", a_err); end
  endtask

  task automatic test_out_stall();
    logic [AW-1:0] p1, p2;
    p1 = $urandom; p2 = $urandom;
    reset_a();
    send_a(p1);
    send_a(p2);
    total++; if (a_free_in !== 1'b0) begin bad++; $display("FAIL stall_free got=%b want=0", a_free_in); end
    total++; if (a_pkt_out_avail !== 1'b1 || a_pkt_out !== p1) begin
      bad++; $display("FAIL stall_head got=%b/%h want 1/%h", a_pkt_out_avail, a_pkt_out, p1);
    end
    a_put_in = 1'b1; a_pay_in = AP'($urandom);
    tick();
    a_put_in = 1'b0;
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL stall_err got=%b want=1", a_err); end
    total++; if (a_pkt_out !== p1 || a_free_in !== 1'b0) begin
      bad++; $display("FAIL stall_unchanged got=%h free=%b want %h free=0", a_pkt_out, a_free_in, p1);
    end
    a_pkt_out_ready = 1'b1;
    tick();
    total++; if (a_pkt_out_avail !== 1'b1 || a_pkt_out !== p2) begin
      bad++; $display("FAIL stall_drain2 got=%b/%h want 1/%h", a_pkt_out_avail, a_pkt_out, p2);
    end
    tick();
    total++; if (a_pkt_out_avail !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b want=0", a_pkt_out_avail); end
    a_pkt_out_ready = 1'b0;
  endtask

  task automatic test_truncated();
    logic [AW-1:0] p;
    p = $urandom;
    reset_a();
    a_pkt_out_ready = 1'b1;
    a_put_in = 1'b1; a_pay_in = 8'hA5;
    tick();
    a_pay_in = 8'h5A;
    tick();
    a_put_in = 1'b0;
    tick();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL trunc_err got=%b want=1", a_err); end
    total++; if (a_pkt_out_avail !== 1'b0) begin bad++; $display("FAIL trunc_nowrite got=%b want=0", a_pkt_out_avail); end
    total++; if (a_free_in !== 1'b1) begin bad++; $display("FAIL trunc_free got=%b want=1", a_free_in); end
    send_a(p);
    total++; if (a_pkt_out_avail !== 1'b1 || a_pkt_out !== p) begin
      bad++; $display("FAIL trunc_next got=%b/%h want 1/%h", a_pkt_out_avail, a_pkt_out, p);
    end
  endtask

  task automatic test_random_out();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] p;
    reset_a();
    for (int c = 0; c < 200; c++) begin
      a_free_out = ($urandom % 4) != 0;
      if (a_cq_full === 1'b0 && ($urandom % 2) == 1) begin
        p = $urandom;
        a_pkt_in = p; a_pkt_in_avail = 1'b1;
        exp_q.push_back(p);
      end else begin
        a_pkt_in_avail = 1'b0;
      end
      tick();
    end
    a_pkt_in_avail = 1'b0;
    a_free_out = 1'b1;
    repeat (6 * APH + 8) tick();
    total++; if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rnd_out_count got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_out_pkt%0d want=%h", i, exp_q[i]); end
    end
  endtask

  task automatic test_random_in();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] cur;
    int sent, got, ph;
    bit active;
    sent = 0; got = 0; ph = 0; active = 0; cur = '0;
    reset_a();
    for (int c = 0; c < 3000 && got < 12; c++) begin
      a_pkt_out_ready = ($urandom % 3) != 0;
      if (a_pkt_out_avail === 1'b1 && a_pkt_out_ready) begin
        total++;
        if (got >= exp_q.size() || a_pkt_out !== exp_q[got]) begin
          bad++; $display("FAIL rnd_in_pkt%0d got=%h", got, a_pkt_out);
        end
        got++;
      end
      if (!active && sent < 12 && a_free_in === 1'b1 && ($urandom % 2) == 1) begin
        cur = $urandom;
        exp_q.push_back(cur);
        sent++;
        active = 1;
        ph = 0;
      end
      if (active) begin
        a_put_in = 1'b1; a_pay_in = a_phit(cur, ph);
        ph++;
        if (ph == APH) active = 0;
      end else begin
        a_put_in = 1'b0;
      end
      tick();
    end
    a_put_in = 1'b0;
    a_pkt_out_ready = 1'b0;
    total++; if (got != 12) begin bad++; $display("FAIL rnd_in_count got=%0d want=12", got); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rnd_in_err got=%b want=0", a_err); end
  endtask

  task automatic test_wide();
    logic [BW-1:0] pk[3];
    logic [BW-1:0] pr;
    int puts;
    pk[0] = 64'h0123456789ABCDEF;
    pk[1] = {$urandom, $urandom};
    pk[2] = {$urandom, $urandom};
    pr    = {$urandom, $urandom};
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    b_free_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_pkt_in = pk[i]; b_pkt_in_avail = 1'b1;
      tick();
    end
    b_pkt_in_avail = 1'b0;
    total++; if (b_cq_full !== 1'b1) begin bad++; $display("FAIL wide_full got=%b want=1", b_cq_full); end
    b_free_out = 1'b1;
    for (int i = 0; i < BPH; i++) begin
      tick();
      total++;
      if (b_put_out !== 1'b1 || b_pay_out !== b_phit(pk[0], i)) begin
        bad++; $display("FAIL wide_phit%0d got put=%b data=%h want 1/%h", i, b_put_out, b_pay_out, b_phit(pk[0], i));
      end
    end
    b_put_in = 1'b1; b_pay_in = 16'hAAAA;
    tick();
    total++; if (b_put_out !== 1'b1 || b_pay_out !== b_phit(pk[1], 0)) begin
      bad++; $display("FAIL wide_b2b got put=%b data=%h want 1/%h", b_put_out, b_pay_out, b_phit(pk[1], 0));
    end
    b_pay_in = 16'hBBBB;
    tick();
    b_rst = 1'b1; b_put_in = 1'b0;
    #1;
    total++; if (b_put_out !== 1'b0 || b_pay_out !== '0) begin
      bad++; $display("FAIL wide_rst_put got put=%b data=%h want 0/0", b_put_out, b_pay_out);
    end
    total++; if (b_cq_full !== 1'b0 || b_free_in !== 1'b1 || b_pkt_out_avail !== 1'b0) begin
      bad++; $display("FAIL wide_rst_q got full=%b free=%b avail=%b want 0/1/0", b_cq_full, b_free_in, b_pkt_out_avail);
    end
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    puts = 0;
    repeat (8) begin
      tick();
      if (b_put_out !== 1'b0) puts++;
    end
    total++; if (puts != 0) begin bad++; $display("FAIL wide_no_survivor got=%0d want=0", puts); end
    for (int i = 0; i < BPH; i++) begin
      b_put_in = 1'b1; b_pay_in = b_phit(pr, i);
      tick();
    end
    b_put_in = 1'b0;
    total++; if (b_pkt_out_avail !== 1'b1 || b_pkt_out !== pr) begin
      bad++; $display("FAIL wide_rx got=%b/%h want 1/%h", b_pkt_out_avail, b_pkt_out, pr);
    end
    total++; if (b_err !== 1'b0) begin bad++; $display("FAIL wide_err got=%b want=0", b_err); end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_full_drop();
    test_inbound();
    test_out_stall();
    test_truncated();
    test_random_out();
    test_random_in();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
